// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings and default vectors for the program counter unit
// Contents:
//   pc_sel_e       next-PC source select (SEQ, TARGET, RET, HOLD)
//   pc_state_e     controller state (RUN, TRAP)
//   DEF_RESET_VEC  default PC after reset
//   DEF_TRAP_VEC   default PC loaded on a misaligned-target trap
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_TARGET = 2'b01,
    PC_SEL_RET    = 2'b10,
    PC_SEL_HOLD   = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_align_chk.sv
// rtl/pc_align_chk.sv - combinational target alignment check
// Configuration: PC_COMPRESSED_EN
//   defined   : 2-byte alignment, only bit[0] is examined
//   undefined : 4-byte alignment, bits[1:0] are examined
// Ports:
//   addr_lo     in   low address bits that must be zero for an aligned target
//   misaligned  out  1 when the target violates the required alignment
module pc_align_chk (
`ifdef PC_COMPRESSED_EN
  input  logic [0:0] addr_lo,
`else
  input  logic [1:0] addr_lo,
`endif
  output logic       misaligned
);

  // The port width already carries the alignment rule, so any set bit traps.
  assign misaligned = |addr_lo;

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with sequential/target/return update and misaligned-target trap
// Configuration: PC_COMPRESSED_EN adds is_c (2-byte SEQ step, 2-byte target alignment)
// Ports:
//   clk         in   clock, all state updates on rising edge
//   rst         in   synchronous active-high reset
//   PC_Update   in   request a PC update this cycle (RUN only)
//   pc_sel      in   next-PC source: 00 SEQ, 01 TARGET, 10 RET, 11 HOLD
//   next_addr   in   branch/jump target
//   trap_ack    in   controller acknowledges the pending trap
//   is_c        in   (PC_COMPRESSED_EN only) current instruction is compressed
//   curr_addr   out  current PC
//   old_addr    out  PC before the last accepted update
//   trap_valid  out  misaligned-target trap pending
//   bad_addr    out  offending target of the last trap
//   epc_addr    out  PC at the time of the last trap
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_Update,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] next_addr,
  input  logic            trap_ack,
`ifdef PC_COMPRESSED_EN
  input  logic            is_c,
`endif
  output logic [XLEN-1:0] curr_addr,
  output logic [XLEN-1:0] old_addr,
  output logic            trap_valid,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] epc_addr
);

  pc_state_e       state, state_nxt;
  logic [XLEN-1:0] curr_nxt, old_nxt, bad_nxt, epc_nxt;
  logic [XLEN-1:0] seq_step;
  logic            misaligned;

`ifdef PC_COMPRESSED_EN
  assign seq_step = is_c ? XLEN'(2) : XLEN'(4);
  pc_align_chk u_align (
    .addr_lo    (next_addr[0:0]),
    .misaligned (misaligned)
  );
`else
  assign seq_step = XLEN'(4);
  pc_align_chk u_align (
    .addr_lo    (next_addr[1:0]),
    .misaligned (misaligned)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      curr_addr <= RESET_VEC;
      old_addr  <= RESET_VEC;
      bad_addr  <= '0;
      epc_addr  <= '0;
    end else begin
      state     <= state_nxt;
      curr_addr <= curr_nxt;
      old_addr  <= old_nxt;
      bad_addr  <= bad_nxt;
      epc_addr  <= epc_nxt;
    end
  end

  // The trap flag is exactly the TRAP state, so no separate register is kept.
  assign trap_valid = (state == ST_TRAP);

  always_comb begin
    state_nxt = state;
    curr_nxt  = curr_addr;
    old_nxt   = old_addr;
    bad_nxt   = bad_addr;
    epc_nxt   = epc_addr;
    unique case (state)
      ST_RUN: begin
        if (PC_Update) begin
          unique case (pc_sel_e'(pc_sel))
            PC_SEL_SEQ: begin
              old_nxt  = curr_addr;
              curr_nxt = curr_addr + seq_step;
            end
            PC_SEL_TARGET: begin
              old_nxt = curr_addr;
              if (misaligned) begin
                curr_nxt  = TRAP_VEC;
                bad_nxt   = next_addr;
                epc_nxt   = curr_addr;
                state_nxt = ST_TRAP;
              end else begin
                curr_nxt = next_addr;
              end
            end
            PC_SEL_RET: begin
              old_nxt  = curr_addr;
              curr_nxt = epc_addr;
            end
            default: ;  // HOLD leaves everything as is
          endcase
        end
      end
      ST_TRAP: begin
        // Updates arriving alongside or before the ack are dropped, not queued.
        if (trap_ack) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit (directed cases plus randomized traffic)
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  typedef struct {
    logic [31:0] curr;
    logic [31:0] old;
    logic        tv;
    logic [31:0] bad;
    logic [31:0] epc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        PC_Update;
  logic [1:0]  pc_sel;
  logic [31:0] next_addr;
  logic        trap_ack;
  logic        is_c;
  logic [31:0] curr_addr, old_addr, bad_addr, epc_addr;
  logic        trap_valid;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference state: what the PC architecturally holds after each edge.
  logic [31:0] m_pc, m_old, m_bad, m_epc;
  logic        m_trap;

  pc_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC_Update  (PC_Update),
    .pc_sel     (pc_sel),
    .next_addr  (next_addr),
    .trap_ack   (trap_ack),
`ifdef PC_COMPRESSED_EN
    .is_c       (is_c),
`endif
    .curr_addr  (curr_addr),
    .old_addr   (old_addr),
    .trap_valid (trap_valid),
    .bad_addr   (bad_addr),
    .epc_addr   (epc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_misaligned(input logic [31:0] a);
`ifdef PC_COMPRESSED_EN
    return a[0];
`else
    return (a % 4) != 0;
`endif
  endfunction

  function automatic logic [31:0] step_of(input logic c);
`ifdef PC_COMPRESSED_EN
    return c ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  // Apply one cycle of inputs to the reference model.
  task automatic model_step(input logic r, input logic u, input logic [1:0] s,
                            input logic [31:0] a, input logic k, input logic c);
    if (r) begin
      m_pc = RV; m_old = RV; m_bad = 0; m_epc = 0; m_trap = 0;
    end else if (m_trap) begin
      if (k) m_trap = 0;
    end else if (u && s != 2'd3) begin
      m_old = m_pc;
      if (s == 2'd0) m_pc = m_pc + step_of(c);
      else if (s == 2'd2) m_pc = m_epc;
      else if (is_misaligned(a)) begin
        m_epc = m_pc; m_bad = a; m_pc = TV; m_trap = 1;
      end else m_pc = a;
    end
  endtask

  task automatic cyc(input logic r, input logic u, input logic [1:0] s,
                     input logic [31:0] a, input logic k, input logic c);
    exp_t e;
    @(negedge clk);
    rst = r; PC_Update = u; pc_sel = s; next_addr = a; trap_ack = k; is_c = c;
    model_step(r, u, s, a, k, c);
    e.curr = m_pc; e.old = m_old; e.tv = m_trap; e.bad = m_bad; e.epc = m_epc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every edge that had stimulus behind it yields one expected record.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("curr_addr", curr_addr, e.curr);
      chk("old_addr", old_addr, e.old);
      chk("trap_valid", {31'd0, trap_valid}, {31'd0, e.tv});
      chk("bad_addr", bad_addr, e.bad);
      chk("epc_addr", epc_addr, e.epc);
    end
  end

  initial begin
    logic        r, u, k, c;
    logic [1:0]  s;
    logic [31:0] a;
    rst = 1; PC_Update = 0; pc_sel = 0; next_addr = 0; trap_ack = 0; is_c = 0;
    m_pc = RV; m_old = RV; m_bad = 0; m_epc = 0; m_trap = 0;

    // Reset then idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Jump to 0x4444 then three sequential steps
    cyc(0, 1, 1, 32'h4444, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // HOLD and idle leave PC alone, trap_ack ignored in RUN
    cyc(0, 1, 3, 32'h1234, 1, 0);
    cyc(0, 0, 0, 32'h5555, 1, 0);
    // Wrap at top of address space
    cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // Misaligned target from 0x4444 traps
    cyc(0, 1, 1, 32'h4444, 0, 0);
    cyc(0, 1, 1, 32'h5555, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h8000, 0, 0);
    // Update with ack: only the ack lands
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 2, 0, 0, 0);
    // Reset while a trap is pending
    cyc(0, 1, 1, 32'h0000_0003, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
`ifdef PC_COMPRESSED_EN
    cyc(0, 1, 1, 32'h10, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 32'h2002, 0, 0);
    cyc(0, 1, 1, 32'h2001, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      u = ($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      k = ($urandom_range(0, 3) == 0);
      c = 1'($urandom_range(0, 1));
      cyc(r, u, s, a, k, c);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000: PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100: PC value loaded on misaligned-target trap.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port PC_Update, input, 1: request to update PC this cycle.
REQ-007 SHALL have port pc_sel, input, 2: next-PC source; 00 SEQ, 01 TARGET, 10 RET, 11 HOLD.
REQ-008 SHALL have port next_addr, input, XLEN: branch/jump target.
REQ-009 SHALL have port trap_ack, input, 1: controller acknowledges a pending trap.
REQ-010 SHALL have port curr_addr, output, XLEN: current PC.
REQ-011 SHALL have port old_addr, output, XLEN: PC value before the last accepted update.
REQ-012 SHALL have port trap_valid, output, 1: misaligned-target trap pending.
REQ-013 SHALL have port bad_addr, output, XLEN: offending target of the last trap.
REQ-014 SHALL have port epc_addr, output, XLEN: PC at the time of the last trap.

Function
REQ-015 SHALL implement two states, RUN and TRAP; updates are accepted only in RUN with PC_Update=1.
REQ-016 SHALL, on accepted SEQ, load curr_addr+4 modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000) one cycle after the request.
REQ-017 SHALL, on accepted TARGET with aligned next_addr (bits[1:0]=00), load next_addr.
REQ-018 SHALL, on accepted TARGET with misaligned next_addr: load TRAP_VEC into curr_addr, next_addr into bad_addr, curr_addr into epc_addr, set trap_valid, enter TRAP, all on the same edge.
REQ-019 SHALL, on accepted RET, load epc_addr into curr_addr.
REQ-020 SHALL, on HOLD or PC_Update=0, keep curr_addr and old_addr unchanged.
REQ-021 SHALL load old_addr with the pre-update curr_addr on every accepted update, including the trap update.
REQ-022 SHALL, in TRAP, ignore PC_Update; trap_ack=1 clears trap_valid and returns to RUN on the next edge.
REQ-023 SHALL, when PC_Update and trap_ack are both high in TRAP, honour only the ack; the update is dropped, not queued.
REQ-024 SHALL ignore trap_ack in RUN.
REQ-025 SHALL keep bad_addr and epc_addr stable until the next trap or reset.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, set curr_addr=old_addr=RESET_VEC, bad_addr=epc_addr=0, trap_valid=0, state RUN; this has priority over all other inputs, including mid-trap.

Configuration
REQ-027 SHALL, with PC_COMPRESSED_EN defined, add input is_c (1 bit): SEQ steps by 2 when is_c=1, else by 4; TARGET is misaligned only when bit[0]=1.
REQ-028 SHALL, without PC_COMPRESSED_EN, have no is_c port, step SEQ by 4, and treat any nonzero bits[1:0] as misaligned.

Structure
REQ-029 SHALL place the pc_sel encodings, the RUN/TRAP state encoding and the default vector constants in shared package pc_pkg.
REQ-030 SHALL implement the alignment check as sub-module pc_align_chk, which is combinational and macro-aware.

Verification
REQ-031 SHALL cover reset: rst=1 for one edge, then idle -> curr_addr=0, old_addr=0, trap_valid=0.
REQ-032 SHALL cover SEQ: from 0x0000_4444, three SEQ updates -> 0x4448, 0x444C, 0x4450; old_addr trails by one value; also 0xFFFF_FFFC+SEQ -> 0x0.
REQ-033 SHALL cover TARGET: next_addr=0x5555 from PC 0x4444 -> curr_addr=0x100, bad_addr=0x5555, epc_addr=0x4444, trap_valid=1; PC_Update ignored until trap_ack; RET then yields 0x4444.
REQ-034 SHALL cover simultaneous PC_Update+trap_ack in TRAP -> only the ack takes effect; curr_addr stays 0x100.
REQ-035 SHALL cover rst asserted while trap_valid=1 -> all outputs return to reset values and the state is RUN.
REQ-036 SHALL cover PC_COMPRESSED_EN: is_c=1 SEQ from 0x10 -> 0x12; TARGET 0x2002 accepted; TARGET 0x2001 traps.
